conf_int_add_pipe: RTL and testbench
====================================

Name: conf_int_add_pipe

Overview:
Pipelined, segmented integer adder with runtime-configurable precision, the next generation of the team's configurable-precision adder.
- Operands are split into SEG_WIDTH-bit segments. One segment is added per pipeline stage, with the carry registered between stages.
- Only the top `prec` bits are kept; lower bits are forced to zero to trade accuracy for energy.
- Sits in the approximate-computing datapath behind a valid/ready stream interface with global backpressure.

Parameters:
- DATA_PATH_BITWIDTH, 16, operand/result width; must be a multiple of SEG_WIDTH (elaboration error otherwise).
- SEG_WIDTH, 4, bits added per stage. NUM_SEG = DATA_PATH_BITWIDTH/SEG_WIDTH = pipeline depth.
- PREC_W, $clog2(DATA_PATH_BITWIDTH)+1, width of the precision input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts an input this cycle.
- a  in  DATA_PATH_BITWIDTH  operand A, unsigned.
- b  in  DATA_PATH_BITWIDTH  operand B, unsigned.
- prec  in  PREC_W  number of active MSBs, sampled with the transaction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  DATA_PATH_BITWIDTH  result.
- cout  out  1  carry out of the MSB segment.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous, active-low.
- Reset: all stage valids cleared; out_valid=0, sum=0, cout=0. in_ready=1 after reset.
- Precision masking:
  - mask = top min(prec, DATA_PATH_BITWIDTH) bits set; prec > DATA_PATH_BITWIDTH is clamped.
  - prec=0 gives sum=0, cout=0.
  - a&mask and b&mask are captured on accept, so prec may change every transaction.
- Pipeline structure:
  - Stage k (1..NUM_SEG) holds: result segments 0..k-1, carry, unconsumed operand segments k..NUM_SEG-1, valid bit.
  - Stage 1 adds segment 0 with carry-in 0.
  - Stage k adds segment k-1 plus the carry from stage k-1.
  - Output registers are stage NUM_SEG.
- Latency: NUM_SEG cycles from accept (in_valid&in_ready) to out_valid, when not stalled. Throughput is one transaction per cycle.
- Backpressure:
  - adv = !out_valid | out_ready; in_ready = adv.
  - When adv=0 the whole pipeline holds; sum and cout are stable while out_valid & !out_ready.
  - No bubble collapsing is required.
- Arithmetic: unsigned modulo 2^DATA_PATH_BITWIDTH. cout = carry out of the top segment; segment carries ripple exactly across stages.
- Simultaneous events:
  - Accept and output handshake in the same cycle both occur.
  - in_valid=0 with adv=1 inserts a bubble (valid=0 propagates).
- Reset mid-operation: all in-flight transactions are discarded and nothing is emitted afterwards. out_valid falls asynchronously.

Optional Feature:
CONF_INT_ADD_SAT_EN
- Defined: when the final carry is 1, sum = all ones (saturate); cout still reports 1.
- Undefined: sum wraps modulo 2^DATA_PATH_BITWIDTH.
- Timing and handshake are identical either way.

Decomposition:
- Package conf_int_add_pkg holds:
  - default SEG_WIDTH constant;
  - prec_mask function (prec, width) -> mask;
  - stage record typedef (valid, partial sum, carry, remaining operands).
- One sub-module, conf_int_add_seg_stage, is natural: one segment adder plus stage register with enable, instantiated NUM_SEG times by generate.

Test Plan:
(DATA_PATH_BITWIDTH=16, SEG_WIDTH=4, latency 4)
- Reset: assert rst=0 with traffic in flight -> out_valid=0, sum=0x0000, cout=0 immediately. in_ready=1 after release.
- a=0x1234, b=0x0FFF, prec=16, out_ready=1 -> 4 cycles later sum=0x2233, cout=0.
- a=0xFFFF, b=0x0001, prec=16 -> sum=0x0000, cout=1 (full carry ripple across all stages). With CONF_INT_ADD_SAT_EN: sum=0xFFFF, cout=1.
- a=0x12FF, b=0x01FF, prec=8 -> sum=0x1300, cout=0. Same operands with prec=0 -> sum=0x0000. prec=31 -> behaves as prec=16: sum=0x14FE.
- Stream 6 back-to-back transactions with out_ready held low for 3 cycles after the first result -> in_ready=0 during the stall, sum stable, all 6 results in order, none lost or duplicated.
- Alternate prec 16/4 every cycle on a=0xABCD, b=0x1111 -> results alternate 0xBCDE and 0xB000.

Source files
------------

// File: rtl/conf_int_add_pkg.sv
// Shared types and helpers for the segmented, precision-configurable pipelined adder.
// Stage records are sized for the widest supported datapath (MAX_W); narrower builds leave the upper bits zero.
package conf_int_add_pkg;

   localparam int SEG_WIDTH_DEF = 4;
   localparam int MAX_W         = 64;

   typedef struct packed {
      logic             valid;
      logic [MAX_W-1:0] psum;
      logic             carry;
      logic [MAX_W-1:0] a_rem;
      logic [MAX_W-1:0] b_rem;
   } stage_t;

   // Top min(prec, width) bits of a width-bit word; a shift by MAX_W or more yields zero.
   function automatic logic [MAX_W-1:0] prec_mask(input int unsigned prec, input int unsigned width);
      logic [MAX_W-1:0] ones;
      logic [MAX_W-1:0] keep;
      logic [MAX_W-1:0] drop;
      int unsigned      p;
      ones = '1;
      p    = (prec > width) ? width : prec;
      keep = ones >> (MAX_W - width);
      drop = ones >> (MAX_W - (width - p));
      return keep & ~drop;
   endfunction

endpackage

// File: rtl/conf_int_add_seg_stage.sv
// One pipeline stage: adds operand segment IDX plus the incoming carry and registers the updated record.
module conf_int_add_seg_stage
   import conf_int_add_pkg::*;
#(
   parameter int SEG_WIDTH = SEG_WIDTH_DEF,
   parameter int IDX       = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  stage_t prev,
   output stage_t cur
);

   logic [SEG_WIDTH:0] seg_sum;
   stage_t             nxt;

   // Consumed operand segments are cleared so each record only carries the segments still to be added.
   always_comb begin
      nxt     = prev;
      seg_sum = {1'b0, prev.a_rem[IDX*SEG_WIDTH +: SEG_WIDTH]}
              + {1'b0, prev.b_rem[IDX*SEG_WIDTH +: SEG_WIDTH]}
              + {{SEG_WIDTH{1'b0}}, prev.carry};
      nxt.psum[IDX*SEG_WIDTH +: SEG_WIDTH]  = seg_sum[SEG_WIDTH-1:0];
      nxt.carry                             = seg_sum[SEG_WIDTH];
      nxt.a_rem[IDX*SEG_WIDTH +: SEG_WIDTH] = '0;
      nxt.b_rem[IDX*SEG_WIDTH +: SEG_WIDTH] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur <= '0;
      end else if (en) begin
         cur <= nxt;
      end
   end

endmodule

// File: rtl/conf_int_add_pipe.sv
// Pipelined segmented adder keeping only the top prec bits, behind a valid/ready stream with global stall.
// Define CONF_INT_ADD_SAT_EN to saturate the sum to all ones when the final carry is set.
module conf_int_add_pipe
   import conf_int_add_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int SEG_WIDTH          = SEG_WIDTH_DEF,
   parameter int PREC_W             = $clog2(DATA_PATH_BITWIDTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   input  logic [PREC_W-1:0]             prec,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] sum,
   output logic                          cout
);

   localparam int NUM_SEG = DATA_PATH_BITWIDTH / SEG_WIDTH;

   if ((DATA_PATH_BITWIDTH % SEG_WIDTH) != 0 || DATA_PATH_BITWIDTH > MAX_W) begin : g_bad_cfg
      $error("conf_int_add_pipe: DATA_PATH_BITWIDTH must be a multiple of SEG_WIDTH and at most MAX_W");
   end

   logic [MAX_W-1:0]      mask;
   logic                  adv;
   stage_t                stage_in;
   stage_t                last;
   stage_t [NUM_SEG:0]    chain;
   logic                  unused_last;

   assign mask = prec_mask(32'(prec), 32'(DATA_PATH_BITWIDTH));
   assign adv  = !out_valid || out_ready;

   // Masked operands are captured with the transaction, so prec may differ on every accept.
   always_comb begin
      stage_in       = '0;
      stage_in.valid = in_valid;
      stage_in.a_rem = MAX_W'(a) & mask;
      stage_in.b_rem = MAX_W'(b) & mask;
   end

   assign chain[0] = stage_in;

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
      conf_int_add_seg_stage #(
         .SEG_WIDTH (SEG_WIDTH),
         .IDX       (k)
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .en   (adv),
         .prev (chain[k]),
         .cur  (chain[k+1])
      );
   end

   assign last      = chain[NUM_SEG];
   assign in_ready  = adv;
   assign out_valid = last.valid;
   assign cout      = last.carry;

`ifdef CONF_INT_ADD_SAT_EN
   assign sum = last.carry ? '1 : last.psum[DATA_PATH_BITWIDTH-1:0];
`else
   assign sum = last.psum[DATA_PATH_BITWIDTH-1:0];
`endif

   // Operand fields of the final record and psum bits above the datapath are never needed downstream.
   assign unused_last = ^{last.a_rem, last.b_rem, last.psum};

endmodule

// File: tb/tb_conf_int_add_pipe.sv
// Directed self-checking bench for conf_int_add_pipe (16-bit datapath, 4-bit segments, latency 4).
module tb_conf_int_add_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [4:0]  prec;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;

   int checks;
   int errors;

   logic [15:0] tx_a[$];
   logic [15:0] tx_b[$];
   logic [4:0]  tx_p[$];
   logic [15:0] exp_s[$];
   logic        exp_c[$];

   conf_int_add_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .prec      (prec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [15:0] sat_exp(input logic [15:0] s, input logic c);
`ifdef CONF_INT_ADD_SAT_EN
      return c ? 16'hFFFF : s;
`else
      return (c === 1'b1) ? s : s;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] va, input logic [15:0] vb,
                                input logic [4:0] vp);
      in_valid = v;
      a        = va;
      b        = vb;
      prec     = vp;
   endtask

   task automatic runOne(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [4:0] vp, input logic [15:0] es, input logic ec);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      applyStimulus(1'b1, va, vb, vp);
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      checkOutput({tag, " latency"}, lat, 4);
      checkOutput({tag, " sum"}, sum, sat_exp(es, ec));
      checkOutput({tag, " cout"}, cout, ec);
   endtask

   task automatic runStream(input string tag, input int stall_cycles);
      int sent;
      int rcv;
      int stall;
      bit first_done;
      sent       = 0;
      rcv        = 0;
      stall      = 0;
      first_done = 0;
      for (int cyc = 0; cyc < 60 && rcv < exp_s.size(); cyc++) begin
         @(posedge clk); #1;
         if (sent < tx_a.size())
            applyStimulus(1'b1, tx_a[sent], tx_b[sent], tx_p[sent]);
         else
            in_valid = 1'b0;
         if (out_valid && !first_done) begin
            out_ready  = 1'b1;
            first_done = 1;
            stall      = stall_cycles;
         end else if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
         #1;
         if (!out_ready) begin
            checkOutput({tag, " stall in_ready"}, in_ready, 0);
            checkOutput({tag, " stall sum"}, sum, sat_exp(exp_s[rcv], exp_c[rcv]));
         end
         if (out_valid && out_ready) begin
            checkOutput($sformatf("%s result%0d sum", tag, rcv), sum, sat_exp(exp_s[rcv], exp_c[rcv]));
            checkOutput($sformatf("%s result%0d cout", tag, rcv), cout, exp_c[rcv]);
            rcv++;
         end
         if (in_valid && in_ready) sent++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput({tag, " result count"}, rcv, exp_s.size());
   endtask

   initial begin
      int seen;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b0, 16'h0000, 16'h0000, 5'd16);

      // Asynchronous reset with no clock edge involved
      #3 rst = 1'b0;
      #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset sum", sum, 16'h0000);
      checkOutput("reset cout", cout, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      checkOutput("reset in_ready", in_ready, 1);

      runOne("basic",   16'h1234, 16'h0FFF, 5'd16, 16'h2233, 1'b0);
      runOne("ripple",  16'hFFFF, 16'h0001, 5'd16, 16'h0000, 1'b1);
      runOne("prec8",   16'h12FF, 16'h01FF, 5'd8,  16'h1300, 1'b0);
      runOne("prec0",   16'h12FF, 16'h01FF, 5'd0,  16'h0000, 1'b0);
      runOne("prec31",  16'h12FF, 16'h01FF, 5'd31, 16'h14FE, 1'b0);

      // Six back-to-back transactions with a three-cycle downstream stall after the first result
      tx_a  = '{16'h0001, 16'h00F0, 16'h8000, 16'h1111, 16'hFFFF, 16'h0F0F};
      tx_b  = '{16'h0002, 16'h0010, 16'h8000, 16'h2222, 16'hFFFF, 16'hF0F0};
      tx_p  = '{5'd16,    5'd16,    5'd16,    5'd16,    5'd12,    5'd8};
      exp_s = '{16'h0003, 16'h0100, 16'h0000, 16'h3333, 16'hFFE0, 16'hFF00};
      exp_c = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
      runStream("stall", 3);

      // Precision toggling every transaction
      tx_a  = '{16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD};
      tx_b  = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111};
      tx_p  = '{5'd16,    5'd4,     5'd16,    5'd4,     5'd16,    5'd4};
      exp_s = '{16'hBCDE, 16'hB000, 16'hBCDE, 16'hB000, 16'hBCDE, 16'hB000};
      exp_c = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0};
      runStream("altprec", 0);

      // Reset with transactions in flight discards them all
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'h1000 + 16'(i), 16'h0101, 5'd16);
         @(posedge clk); #1;
      end
      checkOutput("midrst pre out_valid", out_valid, 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("midrst out_valid", out_valid, 0);
      checkOutput("midrst sum", sum, 16'h0000);
      checkOutput("midrst cout", cout, 0);
      in_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checkOutput("midrst no emission", seen, 0);
      checkOutput("midrst in_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
